// File: rtl/pc_fetch_pkg.sv
// Shared MIPS fetch-side definitions: fetch FSM encodings, reset PC default,
// npc mode encodings and small address helpers.
package pc_fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10,
    ST_ERR  = 2'b11
  } fetch_state_t;

  // Next-PC source selection used by the npc block feeding this fetch stage.
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_mode_t;

  function automatic logic word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_timer.sv
// Fetch wait-cycle counter: expired pulses on the REQ cycle that would make
// the TIMEOUT-th consecutive cycle without a memory response.
module fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = count && (cnt == LIMIT);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: requests pc from imem, holds the word until the
// consumer acks, then loads npc. Optional wait timeout via FETCH_TIMEOUT_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] npc,
  input  logic        instr_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err
);

  fetch_state_t state;
  logic         timed_out;

  assign imem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
  logic timer_clear;
  logic timer_count;

  // Cleared on every transition into REQ so each fetch gets a fresh budget.
  assign timer_clear = (state == ST_IDLE) ||
                       ((state == ST_HOLD) && instr_ack && word_aligned(npc));
  assign timer_count = (state == ST_REQ) && !imem_ready;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timed_out)
  );
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= ST_HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (timed_out) begin
            state     <= ST_ERR;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (instr_ack) begin
            pc          <= npc;
            instr_valid <= 1'b0;
            // A misaligned target is parked in pc so software can inspect it.
            if (word_aligned(npc)) begin
              state    <= ST_REQ;
              imem_req <= 1'b1;
            end else begin
              state     <= ST_ERR;
              fetch_err <= 1'b1;
            end
          end
        end
        default: begin
          state       <= ST_ERR;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
